// File: rtl/div_ctrl_pkg.sv
// Shared encodings for the EX-stage divide sequencer.
// Also carries the aluop codes that steer DIV/DIVU into it.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_step.sv
// One restoring-divide iteration: shift left, trial-subtract the
// divisor from the upper DATA_W+1 bits, keep or restore.
module div_step
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W:0]  work,
    input  logic [DATA_W-1:0]  divisor,
    output logic [2*DATA_W:0]  next
);

    logic [2*DATA_W:0] shifted;
    logic [DATA_W+1:0] diff;
    logic              unused_msb;

    // Partial remainder is always below the divisor, so the top bit
    // is zero before the shift and carries nothing.
    assign unused_msb = work[2*DATA_W];
    assign shifted    = {work[2*DATA_W-1:0], 1'b0};
    assign diff       = {1'b0, shifted[2*DATA_W:DATA_W]}
                      - {2'b00, divisor};

    always_comb begin
        next = shifted;
        if (!diff[DATA_W+1]) begin
            next = {diff[DATA_W:0], shifted[DATA_W-1:1], 1'b1};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer for EX; returns {remainder, quotient}.
// Operands are latched on FREE->ON, so EX may change them freely after.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   dividend_i,
    input  logic [DATA_W-1:0]   divisor_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    div_state_e          state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [2*DATA_W:0]   work, work_n, step;
    logic [DATA_W-1:0]   dvs, dvs_n;
    logic                neg_q, neg_q_n, neg_r, neg_r_n;
    logic [2*DATA_W-1:0] result_n;
    logic                ready_n;
    logic [DATA_W-1:0]   dvd_mag, dvs_mag;
    logic [DATA_W-1:0]   raw_q, raw_r, quo, rem;

    div_step #(.DATA_W(DATA_W)) u_step (
        .work    (work),
        .divisor (dvs),
        .next    (step)
    );

    assign dvd_mag = (signed_i && dividend_i[DATA_W-1])
                   ? -dividend_i : dividend_i;
    assign dvs_mag = (signed_i && divisor_i[DATA_W-1])
                   ? -divisor_i : divisor_i;

    // Fix-up reads the final iteration straight from the step output.
    assign raw_q = step[DATA_W-1:0];
    assign raw_r = step[2*DATA_W-1:DATA_W];
    assign quo   = neg_q ? -raw_q : raw_q;
    assign rem   = neg_r ? -raw_r : raw_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= DivFree;
            cnt      <= '0;
            work     <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            work     <= work_n;
            dvs      <= dvs_n;
            neg_q    <= neg_q_n;
            neg_r    <= neg_r_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        work_n   = work;
        dvs_n    = dvs;
        neg_q_n  = neg_q;
        neg_r_n  = neg_r;
        result_n = result_o;
        ready_n  = ready_o;
        if (annul_i) begin
            state_n  = DivFree;
            ready_n  = DivResultNotReady;
            result_n = '0;
        end else begin
            unique case (state)
                DivFree: begin
                    ready_n  = DivResultNotReady;
                    result_n = '0;
                    if (start_i == DivStart) begin
                        if (divisor_i == '0) begin
                            state_n = DivByZero;
                        end else begin
                            dvs_n   = dvs_mag;
                            neg_q_n = signed_i &
                                (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
                            neg_r_n = signed_i & dividend_i[DATA_W-1];
                            work_n  = {{(DATA_W+1){1'b0}}, dvd_mag};
                            cnt_n   = '0;
                            state_n = DivOn;
                        end
                    end
                end
                DivByZero: begin
                    result_n = '0;
                    state_n  = DivEnd;
                end
                DivOn: begin
                    work_n = step;
                    cnt_n  = cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        result_n = {rem, quo};
                        state_n  = DivEnd;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStart) begin
                        ready_n = DivResultReady;
                    end else begin
                        state_n  = DivFree;
                        ready_n  = DivResultNotReady;
                        result_n = '0;
                    end
                end
                default: state_n = DivFree;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: driver queues model results and
// ready timing, a monitor checks each rising ready_o against them.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic        signed_i = 1'b0;
    logic [31:0] dividend_i = '0;
    logic [31:0] divisor_i = '0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_ready = 1'b0;

    div_ctrl #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] model(input logic sg,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint q, r, sa, sbv;
        if (b == 0) return 64'd0;
        if (sg) begin
            sa  = longint'($signed(a));
            sbv = longint'($signed(b));
        end else begin
            sa  = longint'({32'd0, a});
            sbv = longint'({32'd0, b});
        end
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (ready_o && !prev_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got result %h at cycle %0d expected no ready",
                         result_o, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("result", result_o, mon_e.res);
                check("latency", 64'(cyc), 64'(mon_e.cyc));
            end
        end
        prev_ready = ready_o;
    end

    task automatic run_div(input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input int hold,
                           input bit mid);
        exp_t e;
        bit   got;
        @(negedge clk);
        signed_i   = sg;
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        e.res = model(sg, a, b);
        e.cyc = cyc + 1 + ((b == 0) ? 2 : 33);
        sb.push_back(e);
        got = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (mid && n == 3) begin
                dividend_i = $urandom;
                divisor_i  = $urandom;
                signed_i   = ~signed_i;
            end
            if (ready_o) begin
                got = 1'b1;
                break;
            end
        end
        check("ready_seen", 64'(got), 64'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_ready", 64'(ready_o), 64'd1);
            check("hold_result", result_o, e.res);
        end
        start_i = 1'b0;
        @(negedge clk);
        check("drop_ready", 64'(ready_o), 64'd0);
        check("drop_result", result_o, 64'd0);
    endtask

    task automatic abort_div(input bit use_reset, input int edges);
        @(negedge clk);
        signed_i   = 1'b0;
        dividend_i = 32'd1000;
        divisor_i  = 32'd3;
        start_i    = 1'b1;
        repeat (edges + 1) @(negedge clk);
        start_i = 1'b0;
        if (use_reset) rst = 1'b0;
        else annul_i = 1'b1;
        @(negedge clk);
        rst     = 1'b1;
        annul_i = 1'b0;
        check("abort_ready", 64'(ready_o), 64'd0);
        check("abort_result", result_o, 64'd0);
        repeat (40) begin
            @(negedge clk);
            check("abort_idle", 64'(ready_o), 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        sg;
        logic [31:0] a, b;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);

        run_div(1'b0, 32'd100, 32'd7, 2, 1'b0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1, 1'b0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1'b0);
        run_div(1'b0, 32'd5, 32'd0, 2, 1'b0);
        abort_div(1'b0, 10);
        run_div(1'b0, 32'd9, 32'd3, 1, 1'b0);
        abort_div(1'b1, 20);
        run_div(1'b0, 32'd100, 32'd7, 1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            sg = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_div(sg, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
